mag_comp_seq: RTL and testbench

- Parametrised, multi-cycle magnitude comparator for wide operands in the modular-arithmetic datapath, e.g. Montgomery final-subtraction decision and loop-termination checks.
- Generalises the single-cycle equality compare to full equal/less/greater results.
- Scans operands MSB-first, CHUNK_WIDTH bits per cycle, and exits early on the first differing chunk.
- Supports unsigned and two's-complement signed modes.

---
 rtl/mag_comp_seq.sv | 130 +++++++++++++
 tb/tb_mag_comp_seq.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mag_comp_seq.sv
// Multi-cycle magnitude comparator: scans operands MSB-first, one chunk per enabled
// cycle, and stops at the first differing chunk. Supports unsigned and two's-complement operands.
//
// state | meaning
// IDLE  | waiting for start_cmp; result flags hold the last result
// CMP   | comparing chunk idx_q of the captured operands
// DONE  | done_cmp high for one enabled cycle
module mag_comp_seq #(
    parameter int DATA_WIDTH  = 64,
    parameter int CHUNK_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  start_cmp,
    input  logic                  signed_mode,
    input  logic [DATA_WIDTH-1:0] in0,
    input  logic [DATA_WIDTH-1:0] in1,
    output logic                  busy,
    output logic                  done_cmp,
    output logic                  are_equal,
    output logic                  in0_gt,
    output logic                  in0_lt
);

    localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDX_W-1:0]       IDX_TOP  = IDX_W'(NUM_CHUNKS - 1);
    localparam logic [CHUNK_WIDTH-1:0] MSB_MASK = CHUNK_WIDTH'(1) << (CHUNK_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q;
    logic [IDX_W-1:0]        idx_q;
    logic [IDX_W-1:0]        idx_d;
    logic [DATA_WIDTH-1:0]   a_q;
    logic [DATA_WIDTH-1:0]   b_q;
    logic                    sgn_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    eq_q;
    logic                    gt_q;
    logic                    lt_q;

    logic [CHUNK_WIDTH-1:0]  chunk_a;
    logic [CHUNK_WIDTH-1:0]  chunk_b;
    logic                    gt_d;
    logic                    lt_d;
    logic                    last_chunk;

    always_comb begin
        chunk_a = '0;
        chunk_b = '0;
        for (int i = 0; i < NUM_CHUNKS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                chunk_a = a_q[i*CHUNK_WIDTH +: CHUNK_WIDTH];
                chunk_b = b_q[i*CHUNK_WIDTH +: CHUNK_WIDTH];
            end
        end
        // Flipping the sign bit turns a signed top-chunk compare into an unsigned one
        if (sgn_q && (idx_q == IDX_TOP)) begin
            chunk_a = chunk_a ^ MSB_MASK;
            chunk_b = chunk_b ^ MSB_MASK;
        end
        gt_d       = (chunk_a > chunk_b);
        lt_d       = (chunk_a < chunk_b);
        last_chunk = (idx_q == '0);
        idx_d      = idx_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= IDX_TOP;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else if (ce) begin
            case (state_q)
                IDLE: begin
                    if (start_cmp) begin
                        a_q     <= in0;
                        b_q     <= in1;
                        sgn_q   <= signed_mode;
                        idx_q   <= IDX_TOP;
                        busy_q  <= 1'b1;
                        state_q <= CMP;
                    end
                end
                CMP: begin
                    if (gt_d || lt_d || last_chunk) begin
                        eq_q    <= ~(gt_d | lt_d);
                        gt_q    <= gt_d;
                        lt_q    <= lt_d;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_d;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done_cmp  = done_q;
    assign are_equal = eq_q;
    assign in0_gt    = gt_q;
    assign in0_lt    = lt_q;

endmodule

// File: tb/tb_mag_comp_seq.sv
// Self-checking bench for mag_comp_seq (16-bit operands, 4-bit chunks): directed table,
// randomized runs against a behavioural model, and stall/reset sequences.
module tb_mag_comp_seq;

    localparam int DW = 16;
    localparam int CW = 4;
    localparam int NC = DW / CW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ce = 1'b1;
    logic          start_cmp = 1'b0;
    logic          signed_mode = 1'b0;
    logic [DW-1:0] in0 = '0;
    logic [DW-1:0] in1 = '0;
    logic          busy, done_cmp, are_equal, in0_gt, in0_lt;

    int n_pass = 0;
    int n_total = 0;

    mag_comp_seq #(.DATA_WIDTH(DW), .CHUNK_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .ce(ce), .start_cmp(start_cmp), .signed_mode(signed_mode),
        .in0(in0), .in1(in1), .busy(busy), .done_cmp(done_cmp),
        .are_equal(are_equal), .in0_gt(in0_gt), .in0_lt(in0_lt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          sm;
        logic [2:0]    flags;   // {eq, gt, lt}
        int            lat;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    function automatic logic [2:0] flags_now();
        return {are_equal, in0_gt, in0_lt};
    endfunction

    // Reference: whole-operand compare, latency from the highest differing bit.
    function automatic void model(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic sm,
                                  output logic [2:0] f, output int lat);
        int hi;
        hi = -1;
        if (a == b) f = 3'b100;
        else if (sm ? ($signed(a) > $signed(b)) : (a > b)) f = 3'b010;
        else f = 3'b001;
        for (int p = 0; p < DW; p++) if (a[p] != b[p]) hi = p;
        lat = (hi < 0) ? NC + 1 : NC - hi / CW + 1;
    endfunction

    // Called at a negedge in an IDLE cycle; returns at the negedge of the IDLE cycle after DONE.
    task automatic run_cmp(input string nm, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic sm, input logic [2:0] ef, input int elat);
        logic [2:0] prev;
        int k;
        prev = flags_now();
        in0 = a; in1 = b; signed_mode = sm; start_cmp = 1'b1;
        @(negedge clk);
        start_cmp = 1'b0;
        in0 = DW'($urandom); in1 = DW'($urandom); signed_mode = ~sm;
        k = 1;
        while (!done_cmp && k < 40) begin
            chk({nm, "_busy"}, busy, 1);
            chk({nm, "_hold"}, flags_now(), prev);
            @(negedge clk);
            k++;
        end
        chk({nm, "_done_seen"}, done_cmp, 1);
        chk({nm, "_latency"}, k, elat);
        chk({nm, "_flags"}, flags_now(), ef);
        chk({nm, "_busy_done"}, busy, 1);
        @(negedge clk);
        chk({nm, "_pulse_end"}, done_cmp, 0);
        chk({nm, "_idle_busy"}, busy, 0);
        chk({nm, "_flags_kept"}, flags_now(), ef);
    endtask

    vec_t vecs[9];

    initial begin
        logic [2:0] f;
        int lat, k;
        logic [DW-1:0] a, b;
        logic sm;

        vecs[0] = '{16'h5555, 16'h1555, 1'b0, 3'b010, 2};
        vecs[1] = '{16'hABCD, 16'hABCD, 1'b0, 3'b100, 5};
        vecs[2] = '{16'hABC0, 16'hABCF, 1'b0, 3'b001, 5};
        vecs[3] = '{16'h8000, 16'h0001, 1'b1, 3'b001, 2};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, 3'b010, 2};
        vecs[5] = '{16'hFFFF, 16'h0000, 1'b1, 3'b001, 2};
        vecs[6] = '{16'h7FFF, 16'h8000, 1'b1, 3'b010, 2};
        vecs[7] = '{16'hF0F0, 16'hF1F0, 1'b1, 3'b001, 3};
        vecs[8] = '{16'h1234, 16'h1235, 1'b1, 3'b001, 5};

        // Reset
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done_cmp, 0);
        chk("rst_flags", flags_now(), 3'b000);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++)
            run_cmp($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].flags, vecs[i].lat);

        // Randomized runs, biased towards shared upper chunks
        for (int i = 0; i < 40; i++) begin
            b = DW'($urandom);
            case ($urandom_range(0, 3))
                0: a = DW'($urandom);
                1: a = b;
                2: a = b ^ DW'($urandom_range(0, 15));
                default: a = b ^ DW'($urandom_range(0, 255));
            endcase
            sm = 1'($urandom);
            model(a, b, sm, f, lat);
            run_cmp($sformatf("rnd%0d", i), a, b, sm, f, lat);
        end

        // ce stall with operand change and start pulse while busy
        in0 = 16'hABCD; in1 = 16'hABCD; signed_mode = 1'b0; start_cmp = 1'b1;
        @(negedge clk);                       // S+1
        start_cmp = 1'b0; ce = 1'b0; in0 = 16'h0000;
        @(negedge clk);                       // S+2
        chk("stall_busy", busy, 1);
        chk("stall_nodone", done_cmp, 0);
        start_cmp = 1'b1;
        @(negedge clk);                       // S+3
        start_cmp = 1'b0;
        @(negedge clk);                       // S+4
        ce = 1'b1; start_cmp = 1'b1; in0 = 16'h0001;
        @(negedge clk);                       // S+5
        start_cmp = 1'b0;
        k = 5;
        while (!done_cmp && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("stall_latency", k, 8);
        chk("stall_flags", flags_now(), 3'b100);
        ce = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("stall_done_held", done_cmp, 1);
        end
        ce = 1'b1;
        @(negedge clk);
        chk("stall_pulse_end", done_cmp, 0);
        chk("stall_idle", busy, 0);
        repeat (3) @(negedge clk);
        chk("stall_no_restart", busy, 0);

        // Reset mid-operation
        in0 = 16'hABCD; in1 = 16'hABCD; start_cmp = 1'b1;
        @(negedge clk);                       // S+1
        start_cmp = 1'b0;
        @(negedge clk);                       // S+2
        rst = 1'b0;
        @(negedge clk);                       // S+3
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done_cmp, 0);
        chk("midrst_flags", flags_now(), 3'b000);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("midrst_no_done", {busy, done_cmp}, 2'b00);
        end
        run_cmp("after_rst", 16'h0001, 16'h0002, 1'b0, 3'b001, 5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
